// File: rtl/producer_scheduler_if.sv
// Write-side bundle between the scheduler, the two producers and the CDC buffer.
// The master modport is the scheduler; the slave modport is everything around it.
interface producer_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              start_f_i;
  logic              start_t_i;
  logic              stop_i;
  logic              buffer_full_i;
  logic              buffer_empty_i;
  logic              rd_valid_i;
  logic              f_valid_i;
  logic [DATA_W-1:0] f_data_i;
  logic              t_valid_i;
  logic [DATA_W-1:0] t_data_i;
  logic              f_en_o;
  logic              t_en_o;
  logic              wr_en_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [1:0]        owner_o;
  logic [CNT_W-1:0]  slice_cnt_o;
  logic [5:0]        state_led_o;

  modport master (
    input  start_f_i, start_t_i, stop_i, buffer_full_i, buffer_empty_i, rd_valid_i,
           f_valid_i, f_data_i, t_valid_i, t_data_i,
    output f_en_o, t_en_o, wr_en_o, wr_data_o, owner_o, slice_cnt_o, state_led_o
  );

  modport slave (
    output start_f_i, start_t_i, stop_i, buffer_full_i, buffer_empty_i, rd_valid_i,
           f_valid_i, f_data_i, t_valid_i, t_data_i,
    input  f_en_o, t_en_o, wr_en_o, wr_data_o, owner_o, slice_cnt_o, state_led_o
  );
endinterface

// File: rtl/producer_scheduler.sv
// Round-robin scheduler feeding the Fibonacci and Timer producers into the shared
// CDC buffer. When both producers are armed, ownership passes after QUOTA accepted
// words; buffer-full parks the owner in a WAIT state and stop drains the buffer.
module producer_scheduler #(
  parameter int DATA_W = 16,
  parameter int QUOTA  = 8,
  parameter int CNT_W  = 4
) (
  input logic                 clk,
  input logic                 rst,
  producer_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_F  = 3'd1,
    WAIT_F = 3'd2,
    RUN_T  = 3'd3,
    WAIT_T = 3'd4,
    DRAIN  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QUOTA - 1);

  state_e           state_q, state_d;
  logic             arm_f_q, arm_f_d;
  logic             arm_t_q, arm_t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              f_en;
  logic              t_en;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        owner;
  logic [5:0]        state_led;

  // State, arm flags and slice counter; reset drops everything back to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      arm_f_q <= 1'b0;
      arm_t_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_f_q <= arm_f_d;
      arm_t_q <= arm_t_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: stop beats full, full beats a slice switch; the switch only happens
  // when the other producer was already armed when the last word of the slice lands.
  always_comb begin
    state_d = state_q;
    arm_f_d = arm_f_q;
    arm_t_d = arm_t_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start_f_i) begin
          state_d = RUN_F;
          arm_f_d = 1'b1;
          arm_t_d = bus.start_t_i;
        end else if (bus.start_t_i) begin
          state_d = RUN_T;
          arm_t_d = 1'b1;
        end
      end
      RUN_F, WAIT_F: begin
        if (bus.stop_i) begin
          state_d = DRAIN;
          arm_f_d = 1'b0;
          arm_t_d = 1'b0;
          cnt_d   = '0;
        end else begin
          if (bus.start_t_i) arm_t_d = 1'b1;
          if (state_q == WAIT_F) begin
            if (!bus.buffer_full_i) state_d = RUN_F;
          end else if (bus.buffer_full_i) begin
            state_d = WAIT_F;
          end else if (wr_en) begin
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (arm_t_q) state_d = RUN_T;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      RUN_T, WAIT_T: begin
        if (bus.stop_i) begin
          state_d = DRAIN;
          arm_f_d = 1'b0;
          arm_t_d = 1'b0;
          cnt_d   = '0;
        end else begin
          if (bus.start_f_i) arm_f_d = 1'b1;
          if (state_q == WAIT_T) begin
            if (!bus.buffer_full_i) state_d = RUN_T;
          end else if (bus.buffer_full_i) begin
            state_d = WAIT_T;
          end else if (wr_en) begin
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (arm_f_q) state_d = RUN_F;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (bus.buffer_empty_i && !bus.rd_valid_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        arm_f_d = 1'b0;
        arm_t_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: enables, write port, owner code and LEDs, all straight from state and inputs.
  always_comb begin
    f_en      = 1'b0;
    t_en      = 1'b0;
    wr_data   = '0;
    owner     = 2'd0;
    state_led = 6'b000000;
    case (state_q)
      IDLE: state_led = 6'b000001;
      RUN_F: begin
        f_en      = ~bus.buffer_full_i;
        wr_data   = bus.f_data_i;
        owner     = 2'd1;
        state_led = 6'b000010;
      end
      WAIT_F: begin
        owner     = 2'd1;
        state_led = 6'b000100;
      end
      RUN_T: begin
        t_en      = ~bus.buffer_full_i;
        wr_data   = bus.t_data_i;
        owner     = 2'd2;
        state_led = 6'b001000;
      end
      WAIT_T: begin
        owner     = 2'd2;
        state_led = 6'b010000;
      end
      DRAIN: state_led = 6'b100000;
      default: state_led = 6'b000000;
    endcase
    wr_en = (f_en & bus.f_valid_i) | (t_en & bus.t_valid_i);
  end

  assign bus.f_en_o      = f_en;
  assign bus.t_en_o      = t_en;
  assign bus.wr_en_o     = wr_en;
  assign bus.wr_data_o   = wr_data;
  assign bus.owner_o     = owner;
  assign bus.slice_cnt_o = cnt_q;
  assign bus.state_led_o = state_led;

endmodule

// File: tb/tb_producer_scheduler.sv
// Bench for producer_scheduler: a directed vector table, hand-written corner
// sequences (drain hold, dual start, async reset) and a randomized run against
// a behavioural model of the scheduling rules.
module tb_producer_scheduler;

  localparam int DATA_W = 16;
  localparam int QUOTA  = 8;
  localparam int CNT_W  = 4;

  localparam logic [7:0] SF = 8'h80;
  localparam logic [7:0] ST = 8'h40;
  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] FL = 8'h10;
  localparam logic [7:0] EM = 8'h08;
  localparam logic [7:0] RV = 8'h04;
  localparam logic [7:0] FV = 8'h02;
  localparam logic [7:0] TV = 8'h01;

  typedef struct {
    logic [7:0] ins;
    logic       expWr;
    logic [1:0] expOwner;
    logic [5:0] expLed;
    logic [3:0] expCnt;
    logic [1:0] expSel;
  } vec_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCount;

  int   mMode;
  int   mOwner;
  bit   mWait;
  int   mCnt;
  bit   mArmF;
  bit   mArmT;
  bit   mAccept;

  vec_t vecs[23];

  producer_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  producer_scheduler #(.DATA_W(DATA_W), .QUOTA(QUOTA), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running write-side clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] ins, input logic wr, input logic [1:0] own,
                              input logic [5:0] led, input logic [3:0] cnt, input logic [1:0] sel);
    vec_t v;
    v.ins = ins; v.expWr = wr; v.expOwner = own; v.expLed = led; v.expCnt = cnt; v.expSel = sel;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ins, input logic [15:0] fd, input logic [15:0] td);
    @(negedge clk);
    bus.start_f_i      = ins[7];
    bus.start_t_i      = ins[6];
    bus.stop_i         = ins[5];
    bus.buffer_full_i  = ins[4];
    bus.buffer_empty_i = ins[3];
    bus.rd_valid_i     = ins[2];
    bus.f_valid_i      = ins[1];
    bus.f_data_i       = fd;
    bus.t_valid_i      = ins[0];
    bus.t_data_i       = td;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expWr, input logic [1:0] expOwner,
                             input logic [5:0] expLed, input logic [3:0] expCnt,
                             input logic expFEn, input logic expTEn, input logic [15:0] expData);
    checkField({tag, ".wr_en"}, 32'(bus.wr_en_o), 32'(expWr));
    checkField({tag, ".owner"}, 32'(bus.owner_o), 32'(expOwner));
    checkField({tag, ".state_led"}, 32'(bus.state_led_o), 32'(expLed));
    checkField({tag, ".slice_cnt"}, 32'(bus.slice_cnt_o), 32'(expCnt));
    checkField({tag, ".f_en"}, 32'(bus.f_en_o), 32'(expFEn));
    checkField({tag, ".t_en"}, 32'(bus.t_en_o), 32'(expTEn));
    checkField({tag, ".wr_data"}, 32'(bus.wr_data_o), 32'(expData));
  endtask

  task automatic modelReset();
    mMode = 0; mOwner = 0; mWait = 0; mCnt = 0; mArmF = 0; mArmT = 0;
  endtask

  // Expected outputs from the model's notion of who owns the buffer and whether it is stalled.
  task automatic checkModel(input string tag);
    bit running, fEn, tEn, wr;
    logic [15:0] data;
    logic [5:0]  led;
    running = (mMode == 1) && !mWait;
    fEn     = running && (mOwner == 1) && !bus.buffer_full_i;
    tEn     = running && (mOwner == 2) && !bus.buffer_full_i;
    wr      = (fEn && bus.f_valid_i) || (tEn && bus.t_valid_i);
    data    = (running && mOwner == 1) ? bus.f_data_i : (running && mOwner == 2) ? bus.t_data_i : 16'h0;
    if (mMode == 0)      led = 6'b000001;
    else if (mMode == 2) led = 6'b100000;
    else                 led = 6'(1 << (1 + 2 * (mOwner - 1) + int'(mWait)));
    mAccept = wr;
    checkOutput(tag, wr, (mMode == 1) ? 2'(mOwner) : 2'd0, led, 4'(mCnt), fEn, tEn, data);
  endtask

  task automatic modelStep();
    bit other;
    case (mMode)
      0: begin
        if (bus.start_f_i) begin
          mMode = 1; mOwner = 1; mArmF = 1; mArmT = bus.start_t_i;
        end else if (bus.start_t_i) begin
          mMode = 1; mOwner = 2; mArmT = 1;
        end
        mWait = 0; mCnt = 0;
      end
      1: begin
        if (bus.stop_i) begin
          mMode = 2; mArmF = 0; mArmT = 0; mCnt = 0; mWait = 0;
        end else begin
          other = (mOwner == 1) ? mArmT : mArmF;
          if (mWait) begin
            if (!bus.buffer_full_i) mWait = 0;
          end else if (bus.buffer_full_i) begin
            mWait = 1;
          end else if (mAccept) begin
            if (mCnt == QUOTA - 1) begin
              mCnt = 0;
              if (other) mOwner = 3 - mOwner;
            end else begin
              mCnt++;
            end
          end
          mArmF = mArmF | bus.start_f_i;
          mArmT = mArmT | bus.start_t_i;
        end
      end
      default: begin
        if (bus.buffer_empty_i && !bus.rd_valid_i) mMode = 0;
      end
    endcase
  endtask

  initial begin
    logic [7:0] ins;
    logic [15:0] fd, td, expData;
    testsRun  = 0;
    failCount = 0;
    rst = 1'b1;
    bus.start_f_i = 0; bus.start_t_i = 0; bus.stop_i = 0; bus.buffer_full_i = 0;
    bus.buffer_empty_i = 1; bus.rd_valid_i = 0; bus.f_valid_i = 0; bus.f_data_i = '0;
    bus.t_valid_i = 0; bus.t_data_i = '0;

    vecs[0] = mk(SF | EM, 0, 0, 6'b000001, 0, 0);
    vecs[1] = mk(FV | EM, 1, 1, 6'b000010, 0, 1);
    vecs[2] = mk(FV | ST | EM, 1, 1, 6'b000010, 1, 1);
    for (int i = 3; i <= 8; i++) vecs[i] = mk(FV | EM, 1, 1, 6'b000010, 4'(i - 1), 1);
    vecs[9] = mk(TV | EM, 1, 2, 6'b001000, 0, 2);
    for (int i = 10; i <= 13; i++) vecs[i] = mk(TV | EM, 1, 2, 6'b001000, 4'(i - 9), 2);
    vecs[14] = mk(TV | FL | EM, 0, 2, 6'b001000, 5, 2);
    vecs[15] = mk(TV | FL | EM, 0, 2, 6'b010000, 5, 0);
    vecs[16] = mk(TV | EM, 0, 2, 6'b010000, 5, 0);
    vecs[17] = mk(TV | EM, 1, 2, 6'b001000, 5, 2);
    vecs[18] = mk(TV | SP | FL | EM, 0, 2, 6'b001000, 6, 2);
    vecs[19] = mk(ST, 0, 0, 6'b100000, 0, 0);
    vecs[20] = mk(EM | RV, 0, 0, 6'b100000, 0, 0);
    vecs[21] = mk(EM, 0, 0, 6'b100000, 0, 0);
    vecs[22] = mk(TV | EM, 0, 0, 6'b000001, 0, 0);

    // Reset values while reset is held.
    applyStimulus(FV | TV | EM, 16'h1234, 16'h5678);
    checkOutput("reset", 0, 0, 6'b000001, 0, 0, 0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: slice wrap, switch, full stall, stop+full, drain exit.
    for (int i = 0; i < 23; i++) begin
      fd = 16'hF000 | 16'(i);
      td = 16'h7000 | 16'(i);
      applyStimulus(vecs[i].ins, fd, td);
      expData = (vecs[i].expSel == 1) ? fd : (vecs[i].expSel == 2) ? td : 16'h0;
      checkOutput($sformatf("vec%0d", i), vecs[i].expWr, vecs[i].expOwner, vecs[i].expLed,
                  vecs[i].expCnt, (vecs[i].expSel == 1) && !vecs[i].ins[4],
                  (vecs[i].expSel == 2) && !vecs[i].ins[4], expData);
    end

    // Drain hold: stop with full in RUN_F, then a long non-empty buffer.
    applyStimulus(SF | EM, 16'hA5A5, 16'h5A5A);
    applyStimulus(FV | EM, 16'hA5A5, 16'h5A5A);
    checkField("drain.run_wr", 32'(bus.wr_en_o), 32'd1);
    applyStimulus(FV | SP | FL | EM, 16'hA5A5, 16'h5A5A);
    checkField("drain.stopfull_wr", 32'(bus.wr_en_o), 32'd0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(FV, 16'hA5A5, 16'h5A5A);
      checkField($sformatf("drain.hold%0d_led", k), 32'(bus.state_led_o), 32'h20);
      checkField($sformatf("drain.hold%0d_wr", k), 32'(bus.wr_en_o), 32'd0);
    end
    applyStimulus(EM | RV, 16'hA5A5, 16'h5A5A);
    checkField("drain.rdvalid_led", 32'(bus.state_led_o), 32'h20);
    applyStimulus(EM, 16'hA5A5, 16'h5A5A);
    checkField("drain.exit_led", 32'(bus.state_led_o), 32'h20);

    // Arms cleared by stop: Timer alone must keep the buffer past a full slice.
    applyStimulus(ST | EM, 16'hA5A5, 16'h5A5A);
    checkField("solo.idle_led", 32'(bus.state_led_o), 32'h01);
    for (int k = 0; k < QUOTA; k++) begin
      applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
      checkField($sformatf("solo.cnt%0d", k), 32'(bus.slice_cnt_o), 32'(k));
    end
    applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
    checkField("solo.stay_owner", 32'(bus.owner_o), 32'd2);
    checkField("solo.wrap_cnt", 32'(bus.slice_cnt_o), 32'd0);
    applyStimulus(SP | EM, 16'hA5A5, 16'h5A5A);
    applyStimulus(EM, 16'hA5A5, 16'h5A5A);
    checkField("solo.drain_led", 32'(bus.state_led_o), 32'h20);

    // Dual start in IDLE: Fibonacci first, Timer after QUOTA accepts.
    applyStimulus(SF | ST | EM, 16'hA5A5, 16'h5A5A);
    checkField("dual.idle_led", 32'(bus.state_led_o), 32'h01);
    for (int k = 0; k < QUOTA; k++) begin
      applyStimulus(FV | EM, 16'hA5A5, 16'h5A5A);
      checkField($sformatf("dual.f%0d_led", k), 32'(bus.state_led_o), 32'h02);
    end
    applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
    checkField("dual.switch_owner", 32'(bus.owner_o), 32'd2);
    checkField("dual.switch_data", 32'(bus.wr_data_o), 32'h5A5A);

    // Async reset mid-slice in RUN_T at count 3.
    applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
    applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
    applyStimulus(TV | EM, 16'hA5A5, 16'h5A5A);
    checkField("arst.pre_cnt", 32'(bus.slice_cnt_o), 32'd3);
    #1 rst = 1'b1;
    #1;
    checkField("arst.led", 32'(bus.state_led_o), 32'h01);
    checkField("arst.wr", 32'(bus.wr_en_o), 32'd0);
    checkField("arst.cnt", 32'(bus.slice_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      ins = '0;
      ins[7] = ($urandom_range(0, 7) == 0);
      ins[6] = ($urandom_range(0, 7) == 0);
      ins[5] = ($urandom_range(0, 63) == 0);
      ins[4] = ($urandom_range(0, 5) == 0);
      ins[3] = ($urandom_range(0, 1) == 0);
      ins[2] = ($urandom_range(0, 2) == 0);
      ins[1] = ($urandom_range(0, 3) != 0);
      ins[0] = ($urandom_range(0, 3) != 0);
      applyStimulus(ins, 16'($urandom), 16'($urandom));
      checkModel($sformatf("rnd%0d", c));
      @(posedge clk);
      modelStep();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
